axi_cmd_master: RTL and testbench

AXI4 initiator that turns simple single-command requests into AXI bursts, with one transaction in flight at a time. It is the master-side counterpart of the RAM-backed AXI slave and sits between local logic (DMA engines, test sequencers) and the NOC's slave ports. Writes stream data from a local write port into AW/W/B. Reads return R data on a local read port and report completion status.

---
 rtl/axi_cmd_master.sv | 139 +++++++++++++
 tb/tb_axi_cmd_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_master.sv
// axi_cmd_master: single-outstanding AXI4 initiator turning local commands into INCR bursts.
module axi_cmd_master #(
  parameter int AWID  = 32,
  parameter int IDWID = 4,
  parameter int DWID  = 64,
  parameter int WSTRB = DWID / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [AWID-1:0]  cmd_addr,
  input  logic [7:0]       cmd_len,
  input  logic [IDWID-1:0] cmd_id,
  input  logic [DWID-1:0]  wr_data,
  input  logic [WSTRB-1:0] wr_strb,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [DWID-1:0]  rd_data,
  output logic [1:0]       rd_resp,
  output logic             rd_last,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             done_valid,
  output logic [1:0]       done_resp,
  output logic [IDWID-1:0] done_id,
  output logic [IDWID-1:0] arid,
  output logic [AWID-1:0]  araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic             arvalid,
  input  logic             arready,
  input  logic [IDWID-1:0] rid,
  input  logic [DWID-1:0]  rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             rvalid,
  output logic             rready,
  output logic [IDWID-1:0] awid,
  output logic [AWID-1:0]  awaddr,
  output logic [7:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic             awvalid,
  input  logic             awready,
  output logic [DWID-1:0]  wdata,
  output logic [WSTRB-1:0] wstrb,
  output logic             wlast,
  output logic             wvalid,
  input  logic             wready,
  input  logic [IDWID-1:0] bid,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready
);
  typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;
  state_t state, state_nx;
  logic [AWID-1:0] addr;
  logic [7:0] len;
  logic [IDWID-1:0] id;
  logic [8:0] beat_cnt;
  logic [1:0] resp_acc, r_acc, b_acc;
  logic r_hs, w_hs, b_hs, r_err;
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction
  assign cmd_ready = (state == IDLE);
  assign arvalid = (state == AR);
  assign awvalid = (state == AW);
  assign bready = (state == B);
  assign rready = (state == R) && rd_ready;
  assign rd_valid = (state == R) && rvalid;
  assign wvalid = (state == W) && wr_valid;
  assign wr_ready = (state == W) && wready;
  assign rd_data = rdata;
  assign rd_resp = rresp;
  assign rd_last = rlast;
  assign wdata = wr_data;
  assign wstrb = wr_strb;
  assign wlast = (beat_cnt == {1'b0, len});
  assign arid = id;
  assign awid = id;
  assign araddr = addr;
  assign awaddr = addr;
  assign arlen = len;
  assign awlen = len;
  assign arsize = 3'd3;
  assign awsize = 3'd3;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign done_resp = resp_acc;
  assign done_id = id;
  assign r_hs = rvalid && rready;
  assign w_hs = wvalid && wready;
  assign b_hs = bvalid && bready;
  // A wrong ID or a misplaced rlast floors the response at SLVERR; DECERR survives.
  assign r_err = (rid != id) || (rlast != (beat_cnt == {1'b0, len}));
  assign r_acc = worst(worst(resp_acc, rresp), r_err ? 2'b10 : 2'b00);
  assign b_acc = worst(worst(resp_acc, bresp), (bid != id) ? 2'b10 : 2'b00);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = cmd_valid ? (cmd_write ? AW : AR) : IDLE;
      AR: state_nx = arready ? R : AR;
      R: state_nx = (r_hs && rlast) ? IDLE : R;
      AW: state_nx = awready ? W : AW;
      W: state_nx = (w_hs && wlast) ? B : W;
      B: state_nx = bvalid ? IDLE : B;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      len <= '0;
      id <= '0;
      beat_cnt <= '0;
      resp_acc <= '0;
      done_valid <= 1'b0;
    end else begin
      state <= state_nx;
      done_valid <= (r_hs && rlast) || b_hs;
      if (cmd_valid && cmd_ready) begin
        addr <= cmd_addr & ~AWID'(7);
        len <= cmd_len;
        id <= cmd_id;
        beat_cnt <= '0;
        resp_acc <= '0;
      end else begin
        if (r_hs || w_hs) beat_cnt <= beat_cnt + 9'd1;
        if (r_hs) resp_acc <= r_acc;
        else if (b_hs) resp_acc <= b_acc;
      end
    end
  end
endmodule

// File: tb/tb_axi_cmd_master.sv
// tb_axi_cmd_master: randomized AXI slave stimulus checked against a transaction-level model.
module tb_axi_cmd_master;
  logic clk = 0, rst_n = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0;
  logic [7:0] cmd_len = 0;
  logic [3:0] cmd_id = 0;
  logic [63:0] wr_data = 0, rd_data, rdata = 0, wdata;
  logic [7:0] wr_strb = 0, wstrb;
  logic wr_valid = 0, wr_ready, rd_last, rd_valid, rd_ready = 0, done_valid;
  logic [1:0] rd_resp, done_resp, arburst, awburst, rresp = 0, bresp = 0;
  logic [3:0] done_id, arid, awid, rid = 0, bid = 0;
  logic [31:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic arvalid, arready = 0, rlast = 0, rvalid = 0, rready;
  logic awvalid, awready = 0, wlast, wvalid, wready = 0, bvalid = 0, bready;
  int nt = 0, nf = 0;

  axi_cmd_master dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .done_valid(done_valid), .done_resp(done_resp),
    .done_id(done_id), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] mx(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic send_cmd(input bit wr, input logic [31:0] a, input int ln, input logic [3:0] i);
    logic [51:0] got, ex;
    int d;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = ln[7:0]; cmd_id = i;
    rd_ready = 1; wr_valid = 1; arready = 0; awready = 0;
    #1 nt++;
    if ({cmd_ready, done_valid} !== 2'b10) begin
      nf++; $display("FAIL cmd_idle got %b exp 10", {cmd_ready, done_valid});
    end
    @(negedge clk);
    cmd_valid = 0; cmd_addr = $urandom;
    d = $urandom_range(0, 2);
    ex = {1'b1, 2'b00, a[31:3], 3'b000, ln[7:0], 3'd3, 2'd1, i};
    for (int c = 0; c <= d; c++) begin
      if (c > 0) @(negedge clk);
      arready = !wr && c == d; awready = wr && c == d;
      #1 nt++;
      got = wr ? {awvalid, arvalid, wvalid, awaddr, awlen, awsize, awburst, awid}
               : {arvalid, awvalid, rready, araddr, arlen, arsize, arburst, arid};
      if (got !== ex) begin
        nf++; $display("FAIL addr_phase got %h exp %h", got, ex);
      end
    end
  endtask

  // mode: 0 random rd_ready, 1 toggling 1010.., 2 always ready with back-to-back rvalid
  task automatic rd_phase(input int ln, input logic [3:0] i, input int nb, input int bad,
                          input int mode, input bit rr);
    logic [63:0] d[$];
    logic [1:0] rs[$];
    logic [1:0] ex = 0;
    int beat = 0, cyc = 0;
    for (int b = 0; b < nb; b++) begin
      d.push_back({$urandom, $urandom});
      rs.push_back(rr ? 2'($urandom_range(0, 3)) : 2'b00);
      ex = mx(ex, rs[b]);
    end
    if (nb != ln + 1 || (bad >= 0 && bad < nb)) ex = mx(ex, 2'b10);
    while (beat < nb && cyc < 3000) begin
      @(negedge clk);
      arready = 0; cyc++;
      rvalid = (mode == 2) || ($urandom_range(0, 3) != 0);
      rdata = d[beat]; rresp = rs[beat]; rlast = (beat == nb - 1);
      rid = (beat == bad) ? 4'(i + 1) : i;
      rd_ready = (mode == 1) ? cyc[0] : (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      #1 nt++;
      if ({rready, rd_valid, rd_data, rd_resp, rd_last} !== {rd_ready, rvalid, d[beat], rs[beat], beat == nb - 1}) begin
        nf++;
        $display("FAIL r_beat%0d got %b %b %h %h %b exp %b %b %h %h %b", beat, rready, rd_valid, rd_data,
                 rd_resp, rd_last, rd_ready, rvalid, d[beat], rs[beat], beat == nb - 1);
      end
      if (rvalid && rd_ready) beat++;
    end
    if (beat < nb) begin
      nt++; nf++; $display("FAIL r_timeout got %0d beats exp %0d", beat, nb);
    end
    @(negedge clk);
    rvalid = 0; rlast = 0;
    #1 nt++;
    if ({done_valid, done_resp, done_id, cmd_ready} !== {1'b1, ex, i, 1'b1}) begin
      nf++; $display("FAIL r_done got %b/%0d/%0d/%b exp 1/%0d/%0d/1", done_valid, done_resp, done_id, cmd_ready, ex, i);
    end
  endtask

  task automatic wr_phase(input int ln, input logic [3:0] i, input bit full, input logic [1:0] br, input bit badid);
    logic [1:0] ex;
    int beat = 0, cyc = 0, d;
    ex = badid ? mx(br, 2'b10) : br;
    while (beat <= ln && cyc < 3000) begin
      @(negedge clk);
      awready = 0; cyc++;
      wr_valid = full || ($urandom_range(0, 3) != 0);
      wready = full || ($urandom_range(0, 2) != 0);
      wr_data = {$urandom, $urandom};
      wr_strb = full ? 8'hFF : 8'($urandom);
      #1 nt++;
      if ({wvalid, wr_ready, wdata, wstrb, wlast} !== {wr_valid, wready, wr_data, wr_strb, beat == ln}) begin
        nf++;
        $display("FAIL w_beat%0d got %b %b %h %h %b exp %b %b %h %h %b", beat, wvalid, wr_ready, wdata, wstrb,
                 wlast, wr_valid, wready, wr_data, wr_strb, beat == ln);
      end
      if (wr_valid && wready) beat++;
    end
    if (beat <= ln) begin
      nt++; nf++; $display("FAIL w_timeout got %0d beats exp %0d", beat, ln + 1);
    end
    d = $urandom_range(0, 3);
    for (int c = 0; c <= d; c++) begin
      @(negedge clk);
      wr_valid = 1; wready = 1;
      bvalid = (c == d); bresp = br; bid = badid ? (i ^ 4'h1) : i;
      #1 nt++;
      if ({bready, wvalid, done_valid} !== 3'b100) begin
        nf++; $display("FAIL b_wait got %b exp 100", {bready, wvalid, done_valid});
      end
    end
    @(negedge clk);
    bvalid = 0; wr_valid = 0;
    #1 nt++;
    if ({done_valid, done_resp, done_id, cmd_ready} !== {1'b1, ex, i, 1'b1}) begin
      nf++; $display("FAIL w_done got %b/%0d/%0d/%b exp 1/%0d/%0d/1", done_valid, done_resp, done_id, cmd_ready, ex, i);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1 nt++;
    if ({arvalid, awvalid, wvalid, rready, bready, rd_valid, wr_ready, done_valid, cmd_ready} !== 9'b1) begin
      nf++; $display("FAIL reset_ctrl got %b exp 000000001",
                     {arvalid, awvalid, wvalid, rready, bready, rd_valid, wr_ready, done_valid, cmd_ready});
    end
    nt++;
    if ({araddr, arlen, arid, done_resp} !== 46'd0) begin
      nf++; $display("FAIL reset_regs got %h %h %h %h exp 0", araddr, arlen, arid, done_resp);
    end
    rst_n = 1;
  endtask

  task automatic test_read();
    send_cmd(0, 32'h1003, 3, 4'd5);
    rd_phase(3, 4'd5, 4, -1, 2, 0);
  endtask

  task automatic test_write();
    send_cmd(1, 32'h2000, 7, 4'd9);
    wr_phase(7, 4'd9, 1, 2'b00, 0);
  endtask

  task automatic test_backpressure();
    send_cmd(0, 32'h4000, 15, 4'd3);
    rd_phase(15, 4'd3, 16, -1, 1, 0);
  endtask

  task automatic test_errors();
    send_cmd(1, 32'h5000, 2, 4'd6);
    wr_phase(2, 4'd6, 1, 2'b10, 0);
    send_cmd(1, 32'h5100, 1, 4'd7);
    wr_phase(1, 4'd7, 1, 2'b00, 1);
    send_cmd(0, 32'h5200, 3, 4'd8);
    rd_phase(3, 4'd8, 4, 1, 0, 0);
  endtask

  task automatic test_rlast_errors();
    send_cmd(0, 32'h6000, 3, 4'd2);
    rd_phase(3, 4'd2, 3, -1, 2, 0);
    send_cmd(0, 32'h6100, 3, 4'd4);
    rd_phase(3, 4'd4, 6, -1, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 16; n++) begin
      automatic bit wr = 1'($urandom_range(0, 1));
      automatic int ln = $urandom_range(0, 9);
      automatic logic [3:0] i = 4'($urandom);
      send_cmd(wr, $urandom, ln, i);
      if (wr) wr_phase(ln, i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
      else rd_phase(ln, i, ln + 1 + (($urandom_range(0, 5) == 0) ? 1 : 0), ($urandom_range(0, 4) == 0) ? 0 : -1,
                    $urandom_range(0, 2), 1);
    end
  endtask

  task automatic test_reset_mid_write();
    send_cmd(1, 32'h7000, 7, 4'd3);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      awready = 0; wr_valid = 1; wready = 1; wr_data = {$urandom, $urandom}; wr_strb = 8'hFF;
    end
    @(negedge clk);
    #1 nt++;
    if (wvalid !== 1'b1) begin
      nf++; $display("FAIL mid_wvalid got %b exp 1", wvalid);
    end
    rst_n = 0;
    #1 nt++;
    if ({arvalid, awvalid, wvalid, rready, bready, rd_valid, wr_ready, done_valid, cmd_ready} !== 9'b1) begin
      nf++; $display("FAIL async_reset got %b exp 000000001",
                     {arvalid, awvalid, wvalid, rready, bready, rd_valid, wr_ready, done_valid, cmd_ready});
    end
    @(negedge clk);
    rst_n = 1; wr_valid = 0; wready = 0;
    repeat (4) begin
      @(negedge clk);
      #1 nt++;
      if ({done_valid, cmd_ready} !== 2'b01) begin
        nf++; $display("FAIL post_reset got %b exp 01", {done_valid, cmd_ready});
      end
    end
    send_cmd(0, 32'h8008, 1, 4'd1);
    rd_phase(1, 4'd1, 2, -1, 2, 0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_errors();
    test_rlast_errors();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
